// File: rtl/sum_accumulator.sv
// Saturating burst accumulator behind the 4-bit operand adder.
// It sums N five-bit samples, then holds the total and a sticky overflow flag until the consumer takes them.
module sum_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             accept;

  // One extra bit lets the carry out of the add flag saturation directly.
  assign sum    = {1'b0, acc_q} + {{(ACC_W - 4){1'b0}}, in_sum};
  assign accept = (state_q == ACCUM) && in_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (sum[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
    endcase
  end

  // A clear behaves exactly like a reset and drops whatever is offered that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: two instances (ACC_W=8 and ACC_W=6) share one stimulus stream.
// A burst-level reference model pushes expected results; a negedge monitor pops them when out_valid rises.
module tb_sum_accumulator;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_sum;
  logic       out_ready;

  logic       inReady8, outValid8, outOvf8;
  logic [7:0] outAcc8;
  logic       inReady6, outValid6, outOvf6;
  logic [5:0] outAcc6;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: sum of samples accepted so far in the current burst.
  int  burstTotal = 0;
  int  burstCount = 0;
  bit  modelHold  = 0;
  bit  modelValid = 0;
  int  expAcc8[$];
  int  expOvf8[$];
  int  expAcc6[$];
  int  expOvf6[$];
  int  heldAcc8 = 0, heldOvf8 = 0, heldAcc6 = 0, heldOvf6 = 0;
  bit  prevValid8 = 0, prevValid6 = 0;

  sum_accumulator #(.N(N), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(inReady8), .in_sum(in_sum),
    .out_valid(outValid8), .out_ready(out_ready),
    .out_acc(outAcc8), .out_ovf(outOvf8)
  );

  sum_accumulator #(.N(N), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(inReady6), .in_sum(in_sum),
    .out_valid(outValid6), .out_ready(out_ready),
    .out_acc(outAcc6), .out_ovf(outOvf6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int satValue(int total, int w);
    int maxVal;
    maxVal = (1 << w) - 1;
    return (total > maxVal) ? maxVal : total;
  endfunction

  function automatic int ovfValue(int total, int w);
    return (total > (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  // Since samples are never negative, the running sum saturates during the burst iff the final total exceeds the maximum.
  always @(posedge clk) begin
    if (!rst_n || clear) begin
      burstTotal = 0;
      burstCount = 0;
      modelHold  = 0;
      if (!rst_n) modelValid = 1;
    end else if (modelValid) begin
      if (modelHold) begin
        if (out_ready) begin
          modelHold  = 0;
          burstTotal = 0;
        end
      end else if (in_valid) begin
        burstTotal += int'(in_sum);
        burstCount++;
        if (burstCount == N) begin
          expAcc8.push_back(satValue(burstTotal, 8));
          expOvf8.push_back(ovfValue(burstTotal, 8));
          expAcc6.push_back(satValue(burstTotal, 6));
          expOvf6.push_back(ovfValue(burstTotal, 6));
          burstCount = 0;
          modelHold  = 1;
        end
      end
    end
  end

  // Monitor: handshake flags every cycle, running totals while accumulating, results when presented.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("in_ready8", {31'b0, inReady8}, {31'b0, !modelHold});
      checkOutput("out_valid8", {31'b0, outValid8}, {31'b0, modelHold});
      checkOutput("in_ready6", {31'b0, inReady6}, {31'b0, !modelHold});
      checkOutput("out_valid6", {31'b0, outValid6}, {31'b0, modelHold});
      if (outValid8 && !prevValid8) begin
        if (expAcc8.size() == 0) checkOutput("unexpected result8", 32'd1, 32'd0);
        else begin
          heldAcc8 = expAcc8.pop_front();
          heldOvf8 = expOvf8.pop_front();
          checkOutput("result acc8", {24'b0, outAcc8}, heldAcc8);
          checkOutput("result ovf8", {31'b0, outOvf8}, heldOvf8);
        end
      end else if (outValid8) begin
        checkOutput("held acc8", {24'b0, outAcc8}, heldAcc8);
        checkOutput("held ovf8", {31'b0, outOvf8}, heldOvf8);
      end
      if (outValid6 && !prevValid6) begin
        if (expAcc6.size() == 0) checkOutput("unexpected result6", 32'd1, 32'd0);
        else begin
          heldAcc6 = expAcc6.pop_front();
          heldOvf6 = expOvf6.pop_front();
          checkOutput("result acc6", {26'b0, outAcc6}, heldAcc6);
          checkOutput("result ovf6", {31'b0, outOvf6}, heldOvf6);
        end
      end else if (outValid6) begin
        checkOutput("held acc6", {26'b0, outAcc6}, heldAcc6);
        checkOutput("held ovf6", {31'b0, outOvf6}, heldOvf6);
      end
      if (!modelHold) begin
        checkOutput("running acc8", {24'b0, outAcc8}, satValue(burstTotal, 8));
        checkOutput("running ovf8", {31'b0, outOvf8}, ovfValue(burstTotal, 8));
        checkOutput("running acc6", {26'b0, outAcc6}, satValue(burstTotal, 6));
        checkOutput("running ovf6", {31'b0, outOvf6}, ovfValue(burstTotal, 6));
      end
      prevValid8 = outValid8;
      prevValid6 = outValid6;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one sample and wait, bounded, until it is accepted.
  task automatic applyStimulus(input int value);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_sum   = 5'(value);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (inReady8) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic sendBurst(input int a, input int b, input int c, input int d);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(c);
    applyStimulus(d);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 5'd0;
    out_ready = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] basic burst and saturation");
    sendBurst(3, 5, 7, 9);
    idle(2);
    sendBurst(31, 31, 31, 31);
    sendBurst(1, 1, 1, 1);
    idle(2);

    $display("[TB] backpressure");
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    out_ready = 1'b0;
    applyStimulus(4);
    in_valid = 1'b1;
    in_sum   = 5'd20;
    idle(5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(1);
    sendBurst(20, 0, 0, 0);
    idle(1);

    $display("[TB] input gaps");
    applyStimulus(2);
    idle(1);
    applyStimulus(4);
    idle(3);
    applyStimulus(6);
    idle(2);
    applyStimulus(8);
    idle(2);

    $display("[TB] clear mid-burst");
    applyStimulus(10);
    applyStimulus(10);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_sum   = 5'd10;
    idle(1);
    clear    = 1'b0;
    in_valid = 1'b0;
    sendBurst(1, 2, 3, 4);
    idle(2);

    $display("[TB] reset in hold");
    out_ready = 1'b0;
    sendBurst(3, 5, 7, 9);
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(1);
    sendBurst(3, 5, 7, 9);
    idle(2);

    $display("[TB] randomized bursts");
    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < N; k++) begin
        idle($urandom_range(0, 3));
        if (k == N - 1) out_ready = 1'($urandom_range(0, 1));
        applyStimulus($urandom_range(0, 31));
      end
      if (!out_ready) begin
        idle($urandom_range(1, 4));
        out_ready = 1'b1;
      end
    end
    idle(4);

    checkOutput("queue8 drained", expAcc8.size(), 32'd0);
    checkOutput("queue6 drained", expAcc6.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 4-bit operand adder stage. Takes each sum sample (sum plus carry, 5 bits) over a valid/ready handshake and accumulates N samples into a saturating accumulator. It then presents the burst total with an overflow flag over a second valid/ready handshake. Sits between the adder output and the uo_out pin mux of the tile top.

## Interface
- N, default 4: samples per burst; legal range 1..255.
- ACC_W, default 8: accumulator width; legal range 5..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous burst abort; highest priority after rst_n.
- in_valid  input  1  in_sum holds a sample.
- in_ready  output  1  block can accept a sample; high only in ACCUM state.
- in_sum  input  5  unsigned sample; bit 4 is the adder carry, range 0..31.
- out_valid  output  1  out_acc and out_ovf hold a completed burst.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  burst total, saturated at 2^ACC_W-1.
- out_ovf  output  1  high if saturation occurred anywhere in this burst.

## Operation
- States:
  - ACCUM: collecting samples.
  - HOLD: result presented.
- Internal registers:
  - acc: ACC_W bits.
  - cnt: clog2(N+1) bits.
  - ovf: 1 bit, sticky.
- Outputs are driven as follows:
  - in_ready = (state==ACCUM).
  - out_valid = (state==HOLD).
  - out_acc = acc.
  - out_ovf = ovf.
- Reset (rst_n=0 at an edge): state=ACCUM, acc=0, cnt=0, ovf=0.
  - Output values after reset: in_ready=1, out_valid=0, out_acc=0, out_ovf=0.
  - Reset mid-burst or in HOLD discards everything.
- clear=1 (rst_n=1) at an edge: same effect as reset, in any state.
  - The sample or result offered in that cycle is not consumed.
- ACCUM, in_valid&in_ready at an edge:
  - Compute sum = acc + in_sum at ACC_W+1 bits.
  - If sum > 2^ACC_W-1, then acc = all-ones and ovf = 1. Otherwise acc = sum.
  - cnt = cnt+1.
  - When this is the Nth sample (cnt==N-1 before the edge), go to HOLD. cnt returns to 0.
- ACCUM, in_valid=0: no change. Gaps of any length are allowed.
- HOLD:
  - acc, ovf and state are frozen while out_ready=0.
  - in_valid is ignored, since in_ready=0.
- HOLD, out_ready=1 at an edge: go to ACCUM with acc=0 and ovf=0.
  - No sample is accepted in that same edge, because in_ready was 0 during that cycle.
- Saturation is sticky: once acc is all-ones, later samples keep it all-ones. This includes in_sum=0.
- The upstream side must hold in_sum stable while in_valid=1 and in_ready=0. The block does not check this.

## Timing
- The handshake is zero-latency: a sample or result transfers on any edge where valid&ready=1.
- Latency: out_valid rises on the edge that accepts the Nth sample. out_acc is valid in the cycle immediately after that edge.
- Minimum burst period is N+1 cycles: N accepting cycles plus 1 HOLD cycle when out_ready is tied high.
- All outputs are registered state or decodes of state. There is no combinational path from any input to any output.
- With N=1, every accepted sample produces a HOLD cycle. out_acc equals the sample, or saturates when 31 > 2^ACC_W-1; this is impossible for ACC_W≥5.

## Test plan
- Basic burst (N=4, ACC_W=8): in_valid continuous with in_sum 3,5,7,9, out_ready=1.
  - Required: out_valid=1 for exactly 1 cycle, starting one cycle after the 4th accept, with out_acc=24 and out_ovf=0.
  - Required: in_ready=0 during that cycle and 1 after it.
- Saturation (N=4, ACC_W=6): in_sum 31,31,31,31.
  - Required: out_acc=63 and out_ovf=1.
  - Next burst 1,1,1,1: out_acc=4 and out_ovf=0.
- Backpressure (N=4, ACC_W=8): complete a burst 1,2,3,4, then hold out_ready=0 for 5 cycles while driving in_valid=1 with in_sum=20.
  - Required: out_acc stays 10, in_ready=0 throughout, and the value 20 is never accumulated.
  - After out_ready=1, the next burst 20,0,0,0 gives 20.
- Input gaps (N=4, ACC_W=8): samples 2,4,6,8 sent with 0–3 idle cycles between them.
  - Required: out_acc=20, with out_valid rising exactly one cycle after the 4th accept.
- Clear mid-burst (N=4, ACC_W=8): accept 10,10, then assert clear for 1 cycle while in_valid=1 with in_sum=10.
  - Required: that sample is dropped.
  - The next burst 1,2,3,4 gives out_acc=10 and out_ovf=0.
- Reset in HOLD (N=4, ACC_W=8): reach HOLD with out_acc=24, then pull rst_n low for 1 edge.
  - Required: out_valid=0, out_acc=0, out_ovf=0, in_ready=1.
  - The next full burst 3,5,7,9 gives out_acc=24.
